// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC arbitration for a 5-stage MIPS pipeline
module pc_sequencer #(
    parameter int              WORD         = 32,
    parameter logic [WORD-1:0] EXC_VEC      = 32'h0000_0080,
    parameter int unsigned     DRAIN_CYCLES = 3,
    parameter int              CW           = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] pc_curr,
    input  logic            imem_ready,
    input  logic            hazard_stall,
    input  logic            jump_valid,
    input  logic [WORD-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [WORD-1:0] branch_target,
    input  logic            exc_req,
    output logic [WORD-1:0] pc_next,
    output logic            pc_write,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            exc_ack,
    output logic            busy,
    output logic [CW-1:0]   stall_count
);

    typedef enum logic [1:0] {S_RUN, S_PEND, S_DRAIN} state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t          state_q, state_d;
    logic [WORD-1:0] pend_target_q, pend_target_d;
    logic            pend_exc_q, pend_exc_d;
    logic [3:0]      drain_cnt_q, drain_cnt_d;
    logic [CW-1:0]   stall_count_q, stall_count_d;

    logic            redir;
    logic            redir_exc;
    logic            redir_jump;
    logic [WORD-1:0] redir_target;

    always_comb begin
        redir        = 1'b1;
        redir_exc    = 1'b0;
        redir_jump   = 1'b0;
        redir_target = '0;
        if (exc_req) begin
            redir_exc    = 1'b1;
            redir_target = EXC_VEC;
        end else if (branch_taken) begin
            redir_target = branch_target;
        end else if (jump_valid) begin
            redir_jump   = 1'b1;
            redir_target = jump_target;
        end else begin
            redir        = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pend_exc_d    = pend_exc_q;
        drain_cnt_d   = drain_cnt_q;
        pc_next       = pc_curr;
        pc_write      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        exc_ack       = 1'b0;

        case (state_q)
            S_RUN: begin
                if (redir) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = !redir_jump;
                    exc_ack     = redir_exc;
                    if (imem_ready) begin
                        pc_next  = redir_target;
                        pc_write = 1'b1;
                        if (redir_exc) begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = DRAIN_LOAD;
                        end
                    end else begin
                        pend_target_d = redir_target;
                        pend_exc_d    = redir_exc;
                        state_d       = S_PEND;
                    end
                end else if (imem_ready && !hazard_stall) begin
                    pc_next  = pc_curr + WORD'(4);
                    pc_write = 1'b1;
                end
            end
            S_PEND: begin
                // A late exception replaces a pending jump/branch, but never a pending exception
                if (exc_req && !pend_exc_q) begin
                    exc_ack     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (imem_ready) begin
                        pc_next     = EXC_VEC;
                        pc_write    = 1'b1;
                        pend_exc_d  = 1'b0;
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        pend_target_d = EXC_VEC;
                        pend_exc_d    = 1'b1;
                    end
                end else if (imem_ready) begin
                    pc_next    = pend_target_q;
                    pc_write   = 1'b1;
                    pend_exc_d = 1'b0;
                    if (pend_exc_q) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DRAIN: begin
                if (imem_ready && !hazard_stall) begin
                    pc_next  = pc_curr + WORD'(4);
                    pc_write = 1'b1;
                end
                if (drain_cnt_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            default: state_d = S_RUN;
        endcase

        stall_count_d = stall_count_q;
        if (!pc_write && stall_count_q != {CW{1'b1}}) begin
            stall_count_d = stall_count_q + CW'(1);
        end

        if (reset) begin
            pc_next     = '0;
            pc_write    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            exc_ack     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            pend_target_q <= '0;
            pend_exc_q    <= 1'b0;
            drain_cnt_q   <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            pend_exc_q    <= pend_exc_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign busy        = (state_q != S_RUN);
    assign stall_count = stall_count_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 5-stage MIPS pipeline. It drives the next-PC value and write enable of the PC register, and arbitrates between sequential fetch, jump (ID), taken branch (EX) and exception redirects. It stalls on load-use hazards and instruction-memory wait, buffers a redirect that arrives while fetch is stalled, and sequences a fixed pipeline-drain window after an exception. It also generates the IF/ID and ID/EX flush strobes and keeps a stall-cycle statistic.

Parameters:
word, 32, PC / target width
EXC_VEC, 32'h0000_0080, exception handler address
DRAIN_CYCLES, 3, cycles of drain window after exception (legal range 1..15)
CW, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
pc_curr  in  word  current PC register value
imem_ready  in  1  instruction memory can accept a fetch this cycle
hazard_stall  in  1  load-use hazard from the hazard unit
jump_valid  in  1  jump decoded in ID
jump_target  in  word  jump destination
branch_taken  in  1  branch resolved taken in EX
branch_target  in  word  branch destination
exc_req  in  1  exception request
pc_next  out  word  value to load into the PC
pc_write  out  1  PC write enable
if_id_flush  out  1  kill the IF/ID instruction
id_ex_flush  out  1  kill the ID/EX instruction
exc_ack  out  1  exception accepted (1-cycle pulse)
busy  out  1  state != RUN
stall_count  out  CW  saturating count of cycles with pc_write=0

Behaviour:
- State registers: state {RUN, PEND, DRAIN}, pend_target[word], pend_exc, drain_cnt[3:0], stall_count. All other outputs are combinational from state and inputs.
- Reset (reset=1 at clk edge): state=RUN, pend_target=0, pend_exc=0, drain_cnt=0, stall_count=0. While reset is high, pc_write, if_id_flush, id_ex_flush and exc_ack are 0, and pc_next=0.
- Sequential rule (SEQ): if imem_ready=1 and hazard_stall=0 then pc_next=pc_curr+4 (mod 2^word) and pc_write=1; otherwise pc_write=0 and pc_next=pc_curr.
- Redirect priority in RUN: exc_req > branch_taken > jump_valid. Target is EXC_VEC, branch_target or jump_target respectively. A redirect overrides hazard_stall.
- RUN with a redirect accepted:
  - if_id_flush=1.
  - id_ex_flush=1 for exception or branch; id_ex_flush=0 for jump.
  - exc_ack=1 if the redirect is an exception.
  - If imem_ready=1: pc_next=target, pc_write=1. Next state is DRAIN (drain_cnt=DRAIN_CYCLES-1) for an exception, RUN otherwise.
  - If imem_ready=0: pc_write=0, pend_target<=target, pend_exc<=is_exc, next state PEND.
- RUN with no redirect: apply SEQ. Flushes and exc_ack are 0.
- PEND:
  - branch_taken and jump_valid are ignored.
  - If exc_req=1 and pend_exc=0, the exception wins: exc_ack=1, if_id_flush=1, id_ex_flush=1, target becomes EXC_VEC. If imem_ready=1, pc_next=EXC_VEC, pc_write=1, next state DRAIN. Otherwise pend_target<=EXC_VEC, pend_exc<=1, stay in PEND.
  - Else if imem_ready=1: pc_next=pend_target, pc_write=1, no flush. Next state is DRAIN if pend_exc=1, RUN otherwise.
  - Else: pc_write=0, stay in PEND.
  - exc_req while pend_exc=1 is ignored.
- DRAIN:
  - Apply SEQ.
  - exc_req, branch_taken and jump_valid are ignored; flushes and exc_ack are 0.
  - drain_cnt decrements each cycle. When drain_cnt=0, next state is RUN.
  - DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- pend_exc is cleared on leaving PEND.
- stall_count increments every non-reset cycle with pc_write=0 and saturates at 2^CW-1.
- busy=1 in PEND and DRAIN.

Test Plan:
1. Reset, imem_ready=1, no requests, pc_curr stepped 0,4,8 -> pc_next=4,8,12 with pc_write=1 each cycle. pc_curr=32'hFFFF_FFFC -> pc_next=0.
2. hazard_stall=1 for 2 cycles -> pc_write=0 for both cycles, stall_count=2, no flush.
3. branch_taken=1 (target 0x100) together with jump_valid=1 (0x200) and hazard_stall=1 -> pc_next=0x100, pc_write=1, if_id_flush=1, id_ex_flush=1. Jump alone (0x200) -> id_ex_flush=0.
4. jump to 0x40 with imem_ready=0 for 3 cycles -> flush only in the acceptance cycle. busy=1 and pc_write=0 for 3 cycles; first ready cycle gives pc_next=0x40, pc_write=1, then state RUN. A branch issued during PEND is ignored.
5. exc_req during PEND with pending jump and imem_ready=0 -> exc_ack=1 pulse. On ready, pc_next=0x80, then DRAIN for 3 cycles with branch/exc ignored, then RUN.
6. Reset asserted mid-DRAIN and mid-PEND -> next cycle state RUN, busy=0, stall_count=0. The pending target is discarded and not written.
